// File: rtl/m2s_mem_responder_if.sv
// Request/response channel between an access initiator and m2s_mem_responder.
// The master modport is the initiator side; the slave modport is the responder side.
interface m2s_mem_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_kind;
    logic [ID_W-1:0]   req_id;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_kind, req_id, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_kind, req_id, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/m2s_mem_responder.sv
// In-order load/store responder: request FIFO, fixed-latency word memory, tagged responses.
// Define M2S_RSP_STATS_EN to build the saturating load/store/error response counters.
module m2s_mem_responder #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int ID_W    = 4,
    parameter int QDEPTH  = 4,
    parameter int LATENCY = 4
) (
    input  logic               clk,
    input  logic               reset,
    m2s_mem_responder_if.slave bus,
    output logic               busy,
    output logic [15:0]        stat_loads,
    output logic [15:0]        stat_stores,
    output logic [15:0]        stat_errs
);
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [1:0] KIND_LOAD  = 2'd1;
    localparam logic [1:0] KIND_STORE = 2'd2;

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WAIT, ST_RESP} state_t;

    typedef struct packed {
        logic [1:0]        kind;
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } entry_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_q, clr_d;
    logic [LAT_W-1:0]  lat_q, lat_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    entry_t            svc_q, svc_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic              rsp_is_load_q, rsp_is_load_d;
    logic              rsp_err_q, rsp_err_d;

    logic              full, push, pop;
    logic              mem_we, mem_re;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_dout;
    entry_t            head;

    entry_t            fifo_mem [QDEPTH];
    logic [DATA_W-1:0] mem [2**ADDR_W];

    assign full          = (count_q == CNT_W'(QDEPTH));
    assign bus.req_ready = !full && (state_q != ST_INIT);
    assign push          = bus.req_valid && bus.req_ready;
    assign head          = fifo_mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= '{kind: bus.req_kind, id: bus.req_id,
                                    addr: bus.req_addr, wdata: bus.req_wdata};
        end
    end

    always_comb begin
        state_d       = state_q;
        clr_d         = clr_q;
        lat_d         = lat_q;
        svc_d         = svc_q;
        rsp_id_d      = rsp_id_q;
        rsp_is_load_d = rsp_is_load_q;
        rsp_err_d     = rsp_err_q;
        pop           = 1'b0;
        mem_we        = 1'b0;
        mem_re        = 1'b0;
        mem_waddr     = svc_q.addr;
        mem_wdata     = svc_q.wdata;
        case (state_q)
            ST_INIT: begin
                mem_we    = 1'b1;
                mem_waddr = clr_q;
                mem_wdata = '0;
                clr_d     = clr_q + 1'b1;
                if (clr_q == '1) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    svc_d   = head;
                    lat_d   = LAT_W'(LATENCY - 1);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (lat_q == '0) begin
                    // The access itself happens on the edge that leaves WAIT.
                    state_d       = ST_RESP;
                    rsp_id_d      = svc_q.id;
                    rsp_is_load_d = (svc_q.kind == KIND_LOAD);
                    rsp_err_d     = (svc_q.kind != KIND_LOAD) && (svc_q.kind != KIND_STORE);
                    mem_we        = (svc_q.kind == KIND_STORE);
                    mem_re        = (svc_q.kind == KIND_LOAD);
                end else begin
                    lat_d = lat_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready) begin
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        svc_d   = head;
                        lat_d   = LAT_W'(LATENCY - 1);
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_INIT;
            clr_q         <= '0;
            lat_q         <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            svc_q         <= '0;
            rsp_id_q      <= '0;
            rsp_is_load_q <= 1'b0;
            rsp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            clr_q         <= clr_d;
            lat_q         <= lat_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            svc_q         <= svc_d;
            rsp_id_q      <= rsp_id_d;
            rsp_is_load_q <= rsp_is_load_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    // Single write port shared by the clear sweep and stores; registered read for loads.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
        if (mem_re) mem_dout <= mem[svc_q.addr];
    end

    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_rdata = rsp_is_load_q ? mem_dout : '0;
    assign bus.rsp_err   = rsp_err_q;
    assign busy          = (count_q != '0) || (state_q != ST_IDLE);

`ifdef M2S_RSP_STATS_EN
    logic        rsp_hs;
    logic [15:0] stat_loads_q, stat_loads_d;
    logic [15:0] stat_stores_q, stat_stores_d;
    logic [15:0] stat_errs_q, stat_errs_d;

    assign rsp_hs = (state_q == ST_RESP) && bus.rsp_ready;

    always_comb begin
        stat_loads_d  = stat_loads_q;
        stat_stores_d = stat_stores_q;
        stat_errs_d   = stat_errs_q;
        if (rsp_hs) begin
            if (svc_q.kind == KIND_LOAD) begin
                if (stat_loads_q != 16'hFFFF) stat_loads_d = stat_loads_q + 16'd1;
            end else if (svc_q.kind == KIND_STORE) begin
                if (stat_stores_q != 16'hFFFF) stat_stores_d = stat_stores_q + 16'd1;
            end else begin
                if (stat_errs_q != 16'hFFFF) stat_errs_d = stat_errs_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_loads_q  <= '0;
            stat_stores_q <= '0;
            stat_errs_q   <= '0;
        end else begin
            stat_loads_q  <= stat_loads_d;
            stat_stores_q <= stat_stores_d;
            stat_errs_q   <= stat_errs_d;
        end
    end

    assign stat_loads  = stat_loads_q;
    assign stat_stores = stat_stores_q;
    assign stat_errs   = stat_errs_q;
`else
    assign stat_loads  = '0;
    assign stat_stores = '0;
    assign stat_errs   = '0;
`endif
endmodule

// File: tb/tb_m2s_mem_responder.sv
// Bench for m2s_mem_responder: directed scenarios plus randomized traffic scored
// against an ordered queue of expected responses computed from a word-array memory model.
module tb_m2s_mem_responder;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 32;
    localparam int ID_W    = 4;
    localparam int QDEPTH  = 4;
    localparam int LATENCY = 4;
    localparam int WORDS   = 1 << ADDR_W;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        busy;
    logic [15:0] stat_loads, stat_stores, stat_errs;

    always #5 clk = ~clk;

    m2s_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

    m2s_mem_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .QDEPTH(QDEPTH), .LATENCY(LATENCY)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .busy       (busy),
        .stat_loads (stat_loads),
        .stat_stores(stat_stores),
        .stat_errs  (stat_errs)
    );

    typedef struct {
        logic [1:0]        kind;
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] rdata;
        logic              err;
    } exp_t;

    exp_t              exp_q[$];
    logic [DATA_W-1:0] ref_mem [WORDS];
    int n_cmp = 0;
    int n_mis = 0;
    int cyc = 0;
    int n_ld = 0, n_st = 0, n_er = 0;
    int lat_t0 = 0;
    bit last_acc = 1'b0;
    bit rand_rdy = 1'b0;
    bit lat_armed = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Each request takes effect on the model memory in acceptance order.
    function automatic exp_t model_access(input logic [1:0] kind, input logic [ID_W-1:0] id,
                                          input logic [ADDR_W-1:0] addr,
                                          input logic [DATA_W-1:0] wdata);
        exp_t e;
        e.kind  = kind;
        e.id    = id;
        e.rdata = '0;
        e.err   = 1'b0;
        case (kind)
            2'd1:    e.rdata = ref_mem[addr];
            2'd2:    ref_mem[addr] = wdata;
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    task automatic tick();
        bit acc, hs, rst_pre, busy_pre, vld_pre;
        logic [ID_W-1:0]   g_id;
        logic [DATA_W-1:0] g_rdata;
        logic              g_err;
        exp_t              e;
        if (rand_rdy) bus.rsp_ready = ($urandom_range(0, 3) != 0);
        rst_pre  = reset;
        acc      = bus.req_valid && bus.req_ready && !reset;
        hs       = bus.rsp_valid && bus.rsp_ready && !reset;
        busy_pre = busy;
        vld_pre  = bus.rsp_valid;
        g_id     = bus.rsp_id;
        g_rdata  = bus.rsp_rdata;
        g_err    = bus.rsp_err;
        e = model_access(2'd0, '0, '0, '0);
        @(posedge clk);
        #1;
        cyc++;
        last_acc = acc;
        if (rst_pre) begin
            exp_q.delete();
            foreach (ref_mem[i]) ref_mem[i] = '0;
            n_ld = 0; n_st = 0; n_er = 0;
            lat_armed = 1'b0;
        end else begin
            if (hs) begin
                $display("rsp  cyc=%0d id=%0d rdata=0x%08h err=%0d", cyc, g_id, g_rdata, g_err);
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_rsp", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("rsp_id", 64'(g_id), 64'(e.id));
                    check_eq("rsp_rdata", 64'(g_rdata), 64'(e.rdata));
                    check_eq("rsp_err", 64'(g_err), 64'(e.err));
                    if (e.err) n_er++;
                    else if (e.kind == 2'd1) n_ld++;
                    else n_st++;
                end
            end
            if (acc) begin
                exp_q.push_back(model_access(bus.req_kind, bus.req_id, bus.req_addr, bus.req_wdata));
                if (!busy_pre) begin
                    lat_armed = 1'b1;
                    lat_t0    = cyc;
                end
            end
            if (lat_armed && !vld_pre && bus.rsp_valid) begin
                check_eq("latency", 64'(cyc - lat_t0), 64'(LATENCY + 1));
                lat_armed = 1'b0;
            end
        end
    endtask

    task automatic send_req(input logic [1:0] kind, input logic [ID_W-1:0] id,
                            input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata,
                            input int gap);
        int n;
        n = 0;
        bus.req_valid = 1'b1;
        bus.req_kind  = kind;
        bus.req_id    = id;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        last_acc      = 1'b0;
        while (!last_acc && n < 200) begin
            tick();
            n++;
        end
        if (!last_acc) check_eq("accept_timeout", 64'(last_acc), 64'd1);
        bus.req_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        check_eq({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Called right after the reset edge: req_ready must stay low for exactly one sweep.
    task automatic wait_clear(input string tag);
        int early, vld;
        early = 0;
        vld   = 0;
        for (int k = 0; k < WORDS; k++) begin
            if (bus.req_ready) early++;
            if (bus.rsp_valid) vld++;
            tick();
        end
        check_eq({tag, "_ready_early"}, 64'(early), 64'd0);
        check_eq({tag, "_rsp_valid"}, 64'(vld), 64'd0);
        check_eq({tag, "_ready_rise"}, 64'(bus.req_ready), 64'd1);
    endtask

    task automatic check_stats(input string tag, input int ld, input int st, input int er);
`ifdef M2S_RSP_STATS_EN
        check_eq({tag, "_stat_loads"}, 64'(stat_loads), 64'(ld));
        check_eq({tag, "_stat_stores"}, 64'(stat_stores), 64'(st));
        check_eq({tag, "_stat_errs"}, 64'(stat_errs), 64'(er));
`else
        check_eq({tag, "_stat_loads"}, 64'(stat_loads), 64'(ld * 0));
        check_eq({tag, "_stat_stores"}, 64'(stat_stores), 64'(st * 0));
        check_eq({tag, "_stat_errs"}, 64'(stat_errs), 64'(er * 0));
`endif
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got time limit expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int blocked, n, vld;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        bus.req_valid = 1'b0;
        bus.req_kind  = '0;
        bus.req_id    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_eq("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check_eq("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
        check_eq("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        check_eq("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd1);
        check_stats("rst", 0, 0, 0);
        wait_clear("init");

        // Cleared memory reads back zero
        bus.rsp_ready = 1'b1;
        send_req(2'd1, 4'd0, 8'h55, 32'h0, 0);
        drain("clear");

        // Store then load to the same address
        send_req(2'd2, 4'd1, 8'hAA, 32'h12345678, 0);
        send_req(2'd1, 4'd2, 8'hAA, 32'h0, 0);
        drain("pair");

        // Backpressure: 4 queued + 1 in service, sixth must wait
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_req(2'd1, ID_W'(i), 8'($urandom), 32'h0, 0);
        bus.req_valid = 1'b1;
        bus.req_kind  = 2'd1;
        bus.req_id    = 4'd5;
        bus.req_addr  = 8'($urandom);
        blocked = 0;
        repeat (10) begin
            tick();
            if (last_acc) blocked++;
        end
        check_eq("bp_blocked", 64'(blocked), 64'd0);
        check_eq("bp_ready_low", 64'(bus.req_ready), 64'd0);
        check_eq("bp_rsp_held", 64'(bus.rsp_valid), 64'd1);
        bus.rsp_ready = 1'b1;
        n = 0;
        last_acc = 1'b0;
        while (!last_acc && n < 100) begin
            tick();
            n++;
        end
        check_eq("bp_accept", 64'(last_acc), 64'd1);
        bus.req_valid = 1'b0;
        drain("bp");

        // Invalid kind leaves memory untouched
        a = 8'($urandom);
        d = 32'($urandom);
        send_req(2'd2, 4'd3, a, d, 0);
        send_req(2'd3, 4'd7, a, ~d, 0);
        send_req(2'd1, 4'd8, a, 32'h0, 0);
        drain("invalid");

        // Randomized traffic on a small address window with random consumer stalls
        rand_rdy = 1'b1;
        for (int i = 0; i < 150; i++) begin
            send_req(2'($urandom_range(0, 3)), ID_W'($urandom), {4'hA, 4'($urandom)},
                     32'($urandom), $urandom_range(0, 3));
        end
        rand_rdy = 1'b0;
        bus.rsp_ready = 1'b1;
        drain("random");
        check_stats("random", n_ld, n_st, n_er);

        // Reset while the head request is in WAIT with three more queued
        for (int i = 0; i < 4; i++) send_req(2'd1, ID_W'(i + 9), 8'(i), 32'h0, 0);
        check_eq("mid_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("mid_rst_req_ready", 64'(bus.req_ready), 64'd0);
        wait_clear("mid");
        vld = 0;
        repeat (20) begin
            if (bus.rsp_valid) vld++;
            tick();
        end
        check_eq("mid_stale_rsp", 64'(vld), 64'd0);

        // Counters after 3 loads, 2 stores, 1 invalid
        send_req(2'd2, 4'd1, 8'h10, 32'hCAFEF00D, 0);
        send_req(2'd1, 4'd2, 8'h10, 32'h0, 1);
        send_req(2'd0, 4'd3, 8'h10, 32'h1, 0);
        send_req(2'd1, 4'd4, 8'hA0, 32'h0, 2);
        send_req(2'd2, 4'd5, 8'h11, 32'h00C0FFEE, 0);
        send_req(2'd1, 4'd6, 8'h11, 32'h0, 0);
        drain("stats");
        check_stats("stats", 3, 2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
